// File: rtl/ps2_pkg.sv
// Shared types, error codes and helpers for the PS/2 host transmit path.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    // 64-bit product: 2000 us at 50 MHz already exceeds 32 bits.
    function automatic int unsigned us_to_cycles(input int unsigned us, input int unsigned freq_hz);
        longint unsigned p;
        p = 64'(us) * 64'(freq_hz);
        return 32'(p / 64'd1_000_000);
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Command byte queue; full/empty come from the occupancy count, pointers wrap at DEPTH.
module ps2_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
        else if (pop_ok && !push_ok) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ps2_host_tx_queue.sv
// PS/2 host-to-device transmitter: queued command bytes, ACK check, retry on NACK/timeout.
module ps2_host_tx_queue
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned INHIBIT_US  = 100,
    parameter int unsigned TIMEOUT_US  = 2000,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          CLK_MOUSE_IN,
    input  logic                          DATA_MOUSE_IN,
    output logic                          CLK_MOUSE_OUT_EN,
    output logic                          DATA_MOUSE_OUT,
    output logic                          DATA_MOUSE_OUT_EN,
    input  logic                          SEND_BYTE,
    input  logic [7:0]                    BYTE_TO_SEND,
    output logic                          READY,
    output logic [$clog2(FIFO_DEPTH):0]   QUEUE_COUNT,
    output logic                          BYTE_SENT,
    output logic                          BYTE_ERROR,
    output logic [1:0]                    ERR_CODE
);
    localparam int unsigned INH_CYC  = us_to_cycles(INHIBIT_US, CLK_FREQ_HZ);
    localparam int unsigned TO_CYC   = us_to_cycles(TIMEOUT_US, CLK_FREQ_HZ);
    localparam int unsigned INH_W    = $clog2(INH_CYC + 1);
    localparam int unsigned TO_W     = $clog2(TO_CYC + 1);
    localparam int unsigned RW       = $clog2(MAX_RETRY + 1) + 1;
    localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INH_CYC - 1);
    localparam logic [INH_W-1:0] INH_START = INH_W'(INH_CYC - INH_CYC / 5);
    localparam logic [INH_W-1:0] INH_ONE   = INH_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYC - 1);
    localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
    localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [RW-1:0]    RETRY_ONE = RW'(1);

    logic clk_s1_q, clk_s2_q, clk_prev_q, data_s1_q, data_s2_q;
    logic fall_q, fall_d;

    state_t            state_q, state_d;
    logic [7:0]        byte_q, byte_d;
    logic [9:0]        frame_q, frame_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0]  inh_cnt_q, inh_cnt_d, inh_nxt;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d, to_nxt;
    logic [RW-1:0]     retry_q, retry_d;
    logic              clk_en_q, clk_en_d, data_en_q, data_en_d;
    logic              byte_sent_q, byte_sent_d, byte_error_q, byte_error_d;
    logic [1:0]        err_q, err_d;

    logic        fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        fail, enter_inh, timed_out;
    logic [1:0]  fail_code;

    ps2_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLK),
        .rst_n (RESET_N),
        .push  (SEND_BYTE),
        .wdata (BYTE_TO_SEND),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (QUEUE_COUNT),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fall_d    = clk_prev_q & ~clk_s2_q;
    assign inh_nxt   = inh_cnt_q + INH_ONE;
    assign to_nxt    = fall_q ? '0 : to_cnt_q + TO_ONE;
    assign timed_out = (to_cnt_q == TO_LAST);

    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        frame_d      = frame_q;
        bit_cnt_d    = bit_cnt_q;
        inh_cnt_d    = inh_cnt_q;
        to_cnt_d     = to_cnt_q;
        retry_d      = retry_q;
        clk_en_d     = clk_en_q;
        data_en_d    = data_en_q;
        err_d        = err_q;
        byte_sent_d  = 1'b0;
        byte_error_d = 1'b0;
        fifo_pop     = 1'b0;
        fail         = 1'b0;
        fail_code    = ERR_NONE;
        enter_inh    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    byte_d    = fifo_rdata;
                    retry_d   = '0;
                    enter_inh = 1'b1;
                end
            end
            ST_INHIBIT: begin
                inh_cnt_d = inh_nxt;
                data_en_d = (inh_nxt >= INH_START);
                if (inh_cnt_q == INH_LAST) begin
                    state_d   = ST_REQ;
                    clk_en_d  = 1'b0;
                    data_en_d = 1'b1;
                    to_cnt_d  = '0;
                    bit_cnt_d = '0;
                    frame_d   = {1'b1, odd_parity(byte_q), byte_q};
                end
            end
            ST_REQ, ST_SHIFT: begin
                to_cnt_d = to_nxt;
                if (fall_q) begin
                    data_en_d = ~frame_q[0];
                    frame_d   = frame_q >> 1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    state_d   = ST_SHIFT;
                    if (state_q == ST_SHIFT && bit_cnt_q == 4'd9) begin
                        state_d   = ST_ACK;
                        data_en_d = 1'b0;
                    end
                end else if (timed_out) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            ST_ACK: begin
                to_cnt_d = to_nxt;
                if (fall_q) begin
                    if (!data_s2_q) state_d = ST_WAIT_IDLE;
                    else begin
                        fail      = 1'b1;
                        fail_code = ERR_NACK;
                    end
                end else if (timed_out) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            ST_WAIT_IDLE: begin
                to_cnt_d = to_nxt;
                if (clk_s2_q && data_s2_q) begin
                    byte_sent_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (timed_out) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A failed attempt either restarts INHIBIT with the held byte or drops it.
        if (fail) begin
            clk_en_d  = 1'b0;
            data_en_d = 1'b0;
            err_d     = fail_code;
            if (retry_q < RETRY_MAX) begin
                retry_d   = retry_q + RETRY_ONE;
                enter_inh = 1'b1;
            end else begin
                byte_error_d = 1'b1;
                retry_d      = '0;
                state_d      = ST_IDLE;
            end
        end
        if (enter_inh) begin
            state_d   = ST_INHIBIT;
            inh_cnt_d = '0;
            clk_en_d  = 1'b1;
            data_en_d = (INH_START == '0);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            clk_prev_q   <= 1'b1;
            data_s1_q    <= 1'b1;
            data_s2_q    <= 1'b1;
            fall_q       <= 1'b0;
            state_q      <= ST_IDLE;
            byte_q       <= '0;
            frame_q      <= '0;
            bit_cnt_q    <= '0;
            inh_cnt_q    <= '0;
            to_cnt_q     <= '0;
            retry_q      <= '0;
            clk_en_q     <= 1'b0;
            data_en_q    <= 1'b0;
            byte_sent_q  <= 1'b0;
            byte_error_q <= 1'b0;
            err_q        <= ERR_NONE;
        end else begin
            clk_s1_q     <= CLK_MOUSE_IN;
            clk_s2_q     <= clk_s1_q;
            clk_prev_q   <= clk_s2_q;
            data_s1_q    <= DATA_MOUSE_IN;
            data_s2_q    <= data_s1_q;
            fall_q       <= fall_d;
            state_q      <= state_d;
            byte_q       <= byte_d;
            frame_q      <= frame_d;
            bit_cnt_q    <= bit_cnt_d;
            inh_cnt_q    <= inh_cnt_d;
            to_cnt_q     <= to_cnt_d;
            retry_q      <= retry_d;
            clk_en_q     <= clk_en_d;
            data_en_q    <= data_en_d;
            byte_sent_q  <= byte_sent_d;
            byte_error_q <= byte_error_d;
            err_q        <= err_d;
        end
    end

    assign CLK_MOUSE_OUT_EN  = clk_en_q;
    assign DATA_MOUSE_OUT    = 1'b0;
    assign DATA_MOUSE_OUT_EN = data_en_q;
    assign READY             = ~fifo_full;
    assign BYTE_SENT         = byte_sent_q;
    assign BYTE_ERROR        = byte_error_q;
    assign ERR_CODE          = err_q;

endmodule

// File: tb/tb_ps2_host_tx_queue.sv
// Bench: open-drain line model plus a PS/2 device model; byte/parity expectations from a scoreboard.
module tb_ps2_host_tx_queue;
    localparam int HALF = 40;          // device half period in cycles (1 cycle = 1 us)
    localparam int INH  = 100;         // 100 us at 1 MHz
    localparam int TO   = 2000;        // 2000 us at 1 MHz

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       SEND_BYTE = 1'b0;
    logic [7:0] BYTE_TO_SEND = '0;
    logic       dev_clk = 1'b1, dev_data = 1'b1;
    wire        clk_line, data_line;
    logic       CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT, DATA_MOUSE_OUT_EN;
    logic       READY, BYTE_SENT, BYTE_ERROR;
    logic [2:0] QUEUE_COUNT;
    logic [1:0] ERR_CODE;

    assign clk_line  = dev_clk  & ~CLK_MOUSE_OUT_EN;
    assign data_line = dev_data & ~DATA_MOUSE_OUT_EN;

    ps2_host_tx_queue #(
        .CLK_FREQ_HZ (1_000_000),
        .INHIBIT_US  (100),
        .TIMEOUT_US  (2000),
        .FIFO_DEPTH  (4),
        .MAX_RETRY   (2)
    ) dut (
        .CLK               (CLK),
        .RESET_N           (RESET_N),
        .CLK_MOUSE_IN      (clk_line),
        .DATA_MOUSE_IN     (data_line),
        .CLK_MOUSE_OUT_EN  (CLK_MOUSE_OUT_EN),
        .DATA_MOUSE_OUT    (DATA_MOUSE_OUT),
        .DATA_MOUSE_OUT_EN (DATA_MOUSE_OUT_EN),
        .SEND_BYTE         (SEND_BYTE),
        .BYTE_TO_SEND      (BYTE_TO_SEND),
        .READY             (READY),
        .QUEUE_COUNT       (QUEUE_COUNT),
        .BYTE_SENT         (BYTE_SENT),
        .BYTE_ERROR        (BYTE_ERROR),
        .ERR_CODE          (ERR_CODE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0, n_pass = 0, n_fail = 0;
    int sent_cnt = 0, err_cnt = 0, inh_cnt = 0, cyc = 0;
    int rise_t[$];
    logic clk_en_prev = 1'b0;
    logic [7:0] sb[$];

    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (BYTE_SENT)  sent_cnt = sent_cnt + 1;
        if (BYTE_ERROR) err_cnt  = err_cnt + 1;
        if (CLK_MOUSE_OUT_EN && !clk_en_prev) begin
            inh_cnt = inh_cnt + 1;
            rise_t.push_back(cyc);
        end
        clk_en_prev = CLK_MOUSE_OUT_EN;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        SEND_BYTE = 1'b1;
        BYTE_TO_SEND = b;
        wait_cyc(1);
        SEND_BYTE = 1'b0;
    endtask

    // Odd parity from the definition: ones in byte+P must be odd.
    function automatic logic model_par(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2) == 0;
    endfunction

    task automatic device_frame(input bit nack, input int abort_bit,
                                output logic [7:0] got, output logic par,
                                output logic stp, output bit ok);
        logic [9:0] bits;
        bits = '0; got = '0; par = 1'b0; stp = 1'b0; ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            wait_cyc(1);
            if (!CLK_MOUSE_OUT_EN && DATA_MOUSE_OUT_EN) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        wait_cyc(HALF);
        for (int k = 0; k < 10; k++) begin
            dev_clk = 1'b0;
            wait_cyc(HALF);
            if (k == abort_bit) return;
            bits[k] = data_line;
            dev_clk = 1'b1;
            wait_cyc(HALF);
        end
        got = bits[7:0]; par = bits[8]; stp = bits[9];
        if (!nack) dev_data = 1'b0;
        wait_cyc(HALF);
        dev_clk = 1'b0;
        wait_cyc(HALF);
        dev_clk = 1'b1;
        wait_cyc(HALF);
        dev_data = 1'b1;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] exp, input bit nack);
        logic [7:0] got; logic par, stp; bit ok;
        device_frame(nack, -1, got, par, stp, ok);
        chk({tag, "_rts"}, 32'(ok), 32'd1);
        chk({tag, "_data"}, 32'(got), 32'(exp));
        chk({tag, "_par"}, 32'(par), 32'(model_par(exp)));
        chk({tag, "_stop"}, 32'(stp), 32'd1);
    endtask

    task automatic wait_sent(input int target);
        for (int i = 0; i < 3000 && sent_cnt < target; i++) wait_cyc(1);
    endtask

    initial begin
        int s0, e0, i0, n;
        logic [7:0] got; logic par, stp; bit ok;

        // Reset state
        wait_cyc(3);
        chk("rst_ready", 32'(READY), 32'd1);
        chk("rst_count", 32'(QUEUE_COUNT), 32'd0);
        chk("rst_clk_en", 32'(CLK_MOUSE_OUT_EN), 32'd0);
        chk("rst_data_en", 32'(DATA_MOUSE_OUT_EN), 32'd0);
        chk("rst_data_out", 32'(DATA_MOUSE_OUT), 32'd0);
        chk("rst_sent", 32'(BYTE_SENT), 32'd0);
        chk("rst_error", 32'(BYTE_ERROR), 32'd0);
        chk("rst_err_code", 32'(ERR_CODE), 32'd0);
        RESET_N = 1'b1;
        wait_cyc(2);

        // Single byte with push latency
        s0 = sent_cnt;
        push_byte(8'hF4);
        chk("push_count", 32'(QUEUE_COUNT), 32'd1);
        chk("push_clk_en_early", 32'(CLK_MOUSE_OUT_EN), 32'd0);
        wait_cyc(1);
        chk("push_clk_en_2cyc", 32'(CLK_MOUSE_OUT_EN), 32'd1);
        chk("pop_count", 32'(QUEUE_COUNT), 32'd0);
        check_frame("f4", 8'hF4, 1'b0);
        wait_sent(s0 + 1);
        wait_cyc(5);
        chk("f4_sent", 32'(sent_cnt - s0), 32'd1);
        chk("f4_err_code", 32'(ERR_CODE), 32'd0);

        // Two queued bytes
        s0 = sent_cnt;
        push_byte(8'hF3);
        chk("q_count1", 32'(QUEUE_COUNT), 32'd1);
        push_byte(8'h64);
        chk("q_count2", 32'(QUEUE_COUNT), 32'd1);
        check_frame("f3", 8'hF3, 1'b0);
        check_frame("h64", 8'h64, 1'b0);
        wait_sent(s0 + 2);
        wait_cyc(5);
        chk("q_sent", 32'(sent_cnt - s0), 32'd2);

        // NACK then ACK
        s0 = sent_cnt; e0 = err_cnt; i0 = inh_cnt;
        push_byte(8'hF4);
        device_frame(1'b1, -1, got, par, stp, ok);
        chk("nack_rts", 32'(ok), 32'd1);
        check_frame("retry", 8'hF4, 1'b0);
        wait_sent(s0 + 1);
        wait_cyc(5);
        chk("nack_err_code", 32'(ERR_CODE), 32'd1);
        chk("nack_inhibits", 32'(inh_cnt - i0), 32'd2);
        chk("nack_sent", 32'(sent_cnt - s0), 32'd1);
        chk("nack_errors", 32'(err_cnt - e0), 32'd0);

        // Timeout: device silent
        s0 = sent_cnt; e0 = err_cnt; i0 = inh_cnt;
        push_byte(8'hA5);
        for (int i = 0; i < 7000 && err_cnt == e0; i++) wait_cyc(1);
        wait_cyc(2);
        chk("to_inhibits", 32'(inh_cnt - i0), 32'd3);
        chk("to_errors", 32'(err_cnt - e0), 32'd1);
        chk("to_sent", 32'(sent_cnt - s0), 32'd0);
        chk("to_err_code", 32'(ERR_CODE), 32'd2);
        chk("to_clk_rel", 32'(CLK_MOUSE_OUT_EN), 32'd0);
        chk("to_data_rel", 32'(DATA_MOUSE_OUT_EN), 32'd0);
        n = rise_t.size();
        if (n >= 3) begin
            chk("to_gap1", 32'((rise_t[n-2] - rise_t[n-3]) inside {[INH+TO-3:INH+TO+3]}), 32'd1);
            chk("to_gap2", 32'((rise_t[n-1] - rise_t[n-2]) inside {[INH+TO-3:INH+TO+3]}), 32'd1);
        end else chk("to_rises", 32'(n), 32'd3);
        i0 = inh_cnt;
        wait_cyc(50);
        chk("to_idle", 32'(inh_cnt - i0), 32'd0);

        // Full queue with device stalled
        for (int i = 0; i < 5; i++) push_byte(8'(8'h10 + i));
        chk("full_ready", 32'(READY), 32'd0);
        chk("full_count", 32'(QUEUE_COUNT), 32'd4);
        push_byte(8'hEE);
        chk("full_drop", 32'(QUEUE_COUNT), 32'd4);
        #2 RESET_N = 1'b0;
        #1 chk("full_rst_count", 32'(QUEUE_COUNT), 32'd0);
        wait_cyc(3);
        RESET_N = 1'b1;
        wait_cyc(2);

        // Randomized bytes through the scoreboard
        s0 = sent_cnt;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            sb.push_back(b);
            push_byte(b);
        end
        while (sb.size() > 0) begin
            logic [7:0] b;
            b = sb.pop_front();
            check_frame("rand", b, 1'b0);
        end
        wait_sent(s0 + 4);
        wait_cyc(5);
        chk("rand_sent", 32'(sent_cnt - s0), 32'd4);

        // Reset mid-frame
        push_byte(8'hF4);
        push_byte(8'h55);
        device_frame(1'b0, 3, got, par, stp, ok);
        chk("mid_rts", 32'(ok), 32'd1);
        chk("mid_pre_data_en", 32'(DATA_MOUSE_OUT_EN), 32'd1);
        chk("mid_pre_count", 32'(QUEUE_COUNT), 32'd1);
        #2 RESET_N = 1'b0;
        #1;
        chk("mid_clk_en", 32'(CLK_MOUSE_OUT_EN), 32'd0);
        chk("mid_data_en", 32'(DATA_MOUSE_OUT_EN), 32'd0);
        chk("mid_count", 32'(QUEUE_COUNT), 32'd0);
        dev_clk = 1'b1;
        wait_cyc(3);
        RESET_N = 1'b1;
        wait_cyc(3);
        chk("mid_err_code", 32'(ERR_CODE), 32'd0);
        s0 = sent_cnt;
        push_byte(8'hF4);
        check_frame("post", 8'hF4, 1'b0);
        wait_sent(s0 + 1);
        wait_cyc(5);
        chk("post_sent", 32'(sent_cnt - s0), 32'd1);
        chk("post_err_code", 32'(ERR_CODE), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx_queue.md
# ps2_host_tx_queue

Parametrised PS/2 host-to-device transmitter that buffers a queue of command bytes and sends them one frame at a time over the open-drain mouse clock/data lines. It checks the device acknowledge bit, retries on NACK or timeout, and reports per-byte completion or failure. It sits between the mouse command sequencer and the bidirectional PS/2 pad logic, next to the mouse receiver.

## Interface
Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency
- INHIBIT_US, 100, clock-low inhibit time before the request-to-send
- TIMEOUT_US, 2000, maximum gap between mouse clock falling edges while in a frame
- FIFO_DEPTH, 4, command queue depth; power of two, ≥2
- MAX_RETRY, 2, retries after the first attempt before a byte is dropped

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous, active-low reset
- CLK_MOUSE_IN  in  1  raw PS/2 clock line
- DATA_MOUSE_IN  in  1  raw PS/2 data line
- CLK_MOUSE_OUT_EN  out  1  1 = pull clock low
- DATA_MOUSE_OUT  out  1  data value when driven; always 0
- DATA_MOUSE_OUT_EN  out  1  1 = drive data
- SEND_BYTE  in  1  push strobe, one cycle
- BYTE_TO_SEND  in  8  byte pushed when SEND_BYTE=1
- READY  out  1  queue not full
- QUEUE_COUNT  out  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte in flight
- BYTE_SENT  out  1  one-cycle pulse, byte acknowledged
- BYTE_ERROR  out  1  one-cycle pulse, byte dropped after retries
- ERR_CODE  out  2  00 none, 01 NACK, 10 timeout; holds last error

## Operation
- Inputs: 2-flop synchroniser on both lines. The falling-edge detector on the synchronised clock gives FALL, a one-cycle strobe.
- Push: accepted when SEND_BYTE=1 and READY=1. Pushes while full are dropped, with no other effect.
- Pop: the FSM pops in IDLE when the queue is non-empty. The popped byte is held in a register for the duration of its retries.
- Parity: odd, P = ~^byte. The frame shift register holds {1 stop, P, byte} and shifts out LSB first.
- FSM states and transitions:
  - IDLE: pops and loads the frame, then goes to INHIBIT.
  - INHIBIT: CLK_MOUSE_OUT_EN=1 for INHIBIT_US×CLK_FREQ_HZ/1e6 cycles. In the last 1/5 of this window DATA_MOUSE_OUT_EN=1 as well (start bit), then goes to REQ.
  - REQ: releases the clock and keeps data driven low. The first FALL goes to SHIFT.
  - SHIFT: each FALL presents the next frame bit. Data is driven low for a 0 and released (EN=0) for a 1. After 10 bits (8 data, parity, stop) data is released and the FSM goes to ACK.
  - ACK: on the next FALL, synchronised data=0 goes to WAIT_IDLE; data=1 is a NACK.
  - WAIT_IDLE: waits until both synchronised lines are high, then pulses BYTE_SENT and returns to IDLE.
- Timeout counter:
  - Cleared on entering REQ and on every FALL.
  - Counts in REQ, SHIFT, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_US worth of cycles is a timeout.
- NACK or timeout:
  - Both lines are released and ERR_CODE is set.
  - If retry_cnt < MAX_RETRY: retry_cnt increments and the FSM re-enters INHIBIT with the same byte.
  - Otherwise: BYTE_ERROR pulses, retry_cnt clears and the FSM returns to IDLE.
- retry_cnt clears on each new pop.
- ERR_CODE: a successful send does not clear it. It is cleared only by reset.

## Timing
- Reset (async assert, sync release):
  - FSM=IDLE, queue empty, READY=1, QUEUE_COUNT=0.
  - All *_EN=0, DATA_MOUSE_OUT=0.
  - BYTE_SENT=0, BYTE_ERROR=0, ERR_CODE=00.
- Reset mid-frame releases both lines immediately, as a combinational consequence of the asynchronous state clear.
- Push to QUEUE_COUNT increment: 1 cycle.
- Push into an empty queue with the FSM in IDLE: CLK_MOUSE_OUT_EN rises 2 cycles after SEND_BYTE.
- FALL lags the line by 3 cycles (2 sync + edge register). The data change lands within 1 cycle after FALL, well inside the device's clock-low half period.
- Simultaneous push and pop: both take effect and the count is unchanged. Push while full with a same-cycle pop is accepted.
- Back-to-back bytes: the next INHIBIT starts the cycle after BYTE_SENT.
- The pointers wrap at FIFO_DEPTH. Full/empty is derived from the count, not from pointer equality.

## Structure
- ps2_pkg holds:
  - the state enum;
  - ERR_NONE/ERR_NACK/ERR_TIMEOUT constants;
  - the odd_parity function;
  - the us_to_cycles constant function.
- Sub-module ps2_tx_fifo: parametrised by width and depth. Provides push/pop/count/full/empty with single-cycle behaviour and asynchronous active-low reset.
- Top level: synchronisers, edge detector, FSM, frame shifter, inhibit/timeout counters, retry counter.

## Test plan
- Single byte: push F4; a device model clocks at 40 µs half period and ACKs. DATA bits sampled at the device's rising edges are 0,0,1,0,1,1,1,1, parity 0, stop 1. One BYTE_SENT pulse; ERR_CODE=00.
- Queue: push F3 then 64 on consecutive cycles; QUEUE_COUNT goes 1 then 1 (first popped). Frames appear in order with parities 1 and 0, and there are two BYTE_SENT pulses.
- NACK retry: the device NACKs the first attempt of F4 and ACKs the second. ERR_CODE=01, a second INHIBIT occurs, exactly one BYTE_SENT, and no BYTE_ERROR.
- Timeout: no device clock at all. The bench sees MAX_RETRY+1=3 INHIBIT phases spaced by about the inhibit time plus 2 ms, then one BYTE_ERROR with ERR_CODE=10, both lines released, and the FSM in IDLE.
- Full queue: FIFO_DEPTH=4, device stalled. After 1 byte in flight and 4 queued, READY=0. A 6th push is ignored and QUEUE_COUNT stays 4.
- Reset mid-frame: assert RESET_N=0 at data bit 4. The same cycle gives *_EN=0 and QUEUE_COUNT=0. After release, a push of F4 sends a clean frame.
